// File: rtl/coms_frame_rx_pkg.sv
// Shared constants, FSM states and the byte-wide CRC16 step for the motor-board
// comms path (receiver now, status-frame transmitter later).
package coms_pkg;

    localparam logic [31:0] MAGIC_CTRL = 32'h1CE1CEBB;
    localparam logic [31:0] MAGIC_STAT = 32'hD0D0D0D0;
    localparam logic [31:0] MAGIC_BULK = 32'hBAADA555;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    typedef enum logic [1:0] {HUNT, RECV, CHECK} rx_state_e;

    // MSB-first, unreflected CRC16 over one byte.
    function automatic logic [15:0] crc16_d8(input logic [7:0] data, input logic [15:0] crc);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/coms_frame_rx_if.sv
// Byte stream from uart_rx into the frame receiver.
interface coms_frame_rx_if;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (output rx_valid, rx_data);
    modport slave  (input  rx_valid, rx_data);
endinterface

// File: rtl/coms_frame_rx_crc.sv
// Running CRC16 register: one byte per enabled clock, clear loads the seed
// (and folds in a byte when en is also high).
module crc16_d8_step
    import coms_pkg::*;
(
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)   crc <= '0;
        else if (clear) crc <= en ? crc16_d8(data, CRC16_INIT) : CRC16_INIT;
        else if (en)    crc <= crc16_d8(data, crc);
    end

endmodule

// File: rtl/coms_frame_rx.sv
// Table-driven UART frame receiver: hunts magic numbers, collects the body,
// checks CRC16 and board ID, and presents the payload with a one-cycle strobe.
module coms_frame_rx
    import coms_pkg::*;
#(
    parameter int                        NUM_TYPES    = 3,
    parameter logic [32*NUM_TYPES-1:0]   MAGIC_TABLE  = {MAGIC_BULK, MAGIC_STAT, MAGIC_CTRL},
    parameter logic [8*NUM_TYPES-1:0]    LEN_TABLE    = {8'd22, 8'd6, 8'd3},
    parameter int                        MAX_PAYLOAD  = 19,
    parameter logic [7:0]                BROADCAST_ID = 8'hFF,
    parameter int                        TIMEOUT_CYC  = 50000,
    localparam int                       TW           = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    coms_frame_rx_if.slave           rx,
    input  logic [7:0]               ID,
    output logic                     frame_valid,
    output logic [TW-1:0]            frame_type,
    output logic                     frame_broadcast,
    output logic [8*MAX_PAYLOAD-1:0] payload,
    output logic                     busy,
    output logic [15:0]              crc_err_count,
    output logic [15:0]              timeout_count
);

    localparam int BUF = MAX_PAYLOAD + 3;
    localparam int TMW = $clog2(TIMEOUT_CYC + 1);

    // Configuration sanity, resolved at elaboration.
    if (NUM_TYPES < 1 || NUM_TYPES > 8) begin : g_num_bad
        $fatal(1, "coms_frame_rx: NUM_TYPES %0d out of range", NUM_TYPES);
    end
    for (genvar g = 0; g < NUM_TYPES; g++) begin : g_chk
        if (int'(LEN_TABLE[8*g +: 8]) < 3 || int'(LEN_TABLE[8*g +: 8]) > MAX_PAYLOAD + 3) begin : g_len_bad
            $fatal(1, "coms_frame_rx: LEN_TABLE entry %0d out of range", g);
        end
        for (genvar h = g + 1; h < NUM_TYPES; h++) begin : g_dup
            if (MAGIC_TABLE[32*g +: 32] == MAGIC_TABLE[32*h +: 32]) begin : g_dup_bad
                $fatal(1, "coms_frame_rx: MAGIC_TABLE entries %0d and %0d collide", g, h);
            end
        end
    end

    rx_state_e                state_q, state_d;
    logic [31:0]              hunt;
    logic [TW-1:0]            typ;
    logic [7:0]               cnt;
    logic [TMW-1:0]           timer;
    logic [BUF-1:0][7:0]      shadow;
    logic [NUM_TYPES-1:0][7:0] len_tab;
    logic [NUM_TYPES-1:0]     hit;
    logic                     any_hit;
    logic [TW-1:0]            hit_idx;
    logic [7:0]               cur_len;
    logic [15:0]              crc;
    logic                     crc_clear, crc_en;
    logic                     buf_wr, timeout_hit;
    logic [7:0]               wr_idx, crc_hi, crc_lo;
    logic                     pass, for_me;
    logic [8*MAX_PAYLOAD-1:0] pay_next;

    assign len_tab = LEN_TABLE;
    assign busy    = (state_q != HUNT);

    for (genvar g = 0; g < NUM_TYPES; g++) begin : g_match
        assign hit[g] = (hunt == MAGIC_TABLE[32*g +: 32]);
    end

    always_comb begin
        any_hit = |hit;
        hit_idx = '0;
        for (int t = NUM_TYPES - 1; t >= 0; t--)
            if (hit[t]) hit_idx = TW'(t);
        cur_len = '0;
        for (int t = 0; t < NUM_TYPES; t++)
            if (typ == TW'(t)) cur_len = len_tab[t];
    end

    // A byte landing in the match cycle is already body byte 0.
    always_comb begin
        state_d     = state_q;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;
        buf_wr      = 1'b0;
        wr_idx      = cnt;
        timeout_hit = 1'b0;
        case (state_q)
            HUNT: begin
                wr_idx = 8'd0;
                if (any_hit) begin
                    state_d   = RECV;
                    crc_clear = 1'b1;
                    crc_en    = rx.rx_valid;
                    buf_wr    = rx.rx_valid;
                end
            end
            RECV: begin
                if (rx.rx_valid) begin
                    buf_wr = 1'b1;
                    crc_en = (cnt < cur_len - 8'd2);
                    if (cnt == cur_len - 8'd1) state_d = CHECK;
                end else if (timer == TMW'(TIMEOUT_CYC - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = HUNT;
                end
            end
            CHECK:   state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state_q <= HUNT;
        else          state_q <= state_d;
    end

    crc16_d8_step u_crc (
        .CLK     (CLK),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .en      (crc_en),
        .data    (rx.rx_data),
        .crc     (crc)
    );

    always_comb begin
        crc_hi = '0;
        crc_lo = '0;
        for (int k = 0; k < BUF; k++) begin
            if (8'(k) == cur_len - 8'd2) crc_hi = shadow[k];
            if (8'(k) == cur_len - 8'd1) crc_lo = shadow[k];
        end
        for (int k = 0; k < MAX_PAYLOAD; k++)
            pay_next[8*k +: 8] = (8'(k) < cur_len - 8'd3) ? shadow[k+1] : 8'h00;
        pass   = (crc == {crc_hi, crc_lo});
        for_me = (shadow[0] == ID) || (shadow[0] == BROADCAST_ID);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (buf_wr) begin
            for (int k = 0; k < BUF; k++)
                if (wr_idx == 8'(k)) shadow[k] <= rx.rx_data;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            hunt            <= '0;
            typ             <= '0;
            cnt             <= '0;
            timer           <= '0;
            frame_valid     <= 1'b0;
            frame_type      <= '0;
            frame_broadcast <= 1'b0;
            payload         <= '0;
            crc_err_count   <= '0;
            timeout_count   <= '0;
        end else begin
            frame_valid <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (any_hit) begin
                        typ   <= hit_idx;
                        hunt  <= '0;
                        timer <= '0;
                        cnt   <= rx.rx_valid ? 8'd1 : 8'd0;
                    end else if (rx.rx_valid) begin
                        hunt <= {hunt[23:0], rx.rx_data};
                    end
                end
                RECV: begin
                    if (rx.rx_valid) begin
                        cnt   <= cnt + 8'd1;
                        timer <= '0;
                    end else if (timeout_hit) begin
                        if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
                    end else begin
                        timer <= timer + TMW'(1);
                    end
                end
                CHECK: begin
                    if (rx.rx_valid) hunt <= {hunt[23:0], rx.rx_data};
                    if (pass && for_me) begin
                        payload         <= pay_next;
                        frame_type      <= typ;
                        frame_broadcast <= (shadow[0] == BROADCAST_ID);
                        frame_valid     <= 1'b1;
                    end else if (!pass && crc_err_count != 16'hFFFF) begin
                        crc_err_count <= crc_err_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coms_frame_rx.sv
// Bench for coms_frame_rx: directed vector table, multi-cycle corner sequences,
// then random frames checked against a frame-level reference model.
module tb_coms_frame_rx;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int           t;
        logic [7:0]   idb;
        logic [7:0]   flip;
        int           fv;
        logic [1:0]   ty;
        logic         bc;
        logic [15:0]  err;
        logic [151:0] pl;
    } vec_t;

    logic         CLK = 1'b0;
    logic         reset_n;
    logic [7:0]   ID;
    logic         frame_valid;
    logic [1:0]   frame_type;
    logic         frame_broadcast;
    logic [151:0] payload;
    logic         busy;
    logic [15:0]  crc_err_count;
    logic [15:0]  timeout_count;

    coms_frame_rx_if rx_if();

    coms_frame_rx #(
        .NUM_TYPES    (3),
        .MAGIC_TABLE  ({32'hBAADA555, 32'hD0D0D0D0, 32'h1CE1CEBB}),
        .LEN_TABLE    ({8'd22, 8'd6, 8'd3}),
        .MAX_PAYLOAD  (19),
        .BROADCAST_ID (8'hFF),
        .TIMEOUT_CYC  (100)
    ) dut (
        .CLK             (CLK),
        .reset_n         (reset_n),
        .rx              (rx_if),
        .ID              (ID),
        .frame_valid     (frame_valid),
        .frame_type      (frame_type),
        .frame_broadcast (frame_broadcast),
        .payload         (payload),
        .busy            (busy),
        .crc_err_count   (crc_err_count),
        .timeout_count   (timeout_count)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int fv_q[$];
    always @(negedge CLK) if (frame_valid) fv_q.push_back(cyc);

    int checks = 0;
    int errors = 0;

    // Reference tables and model state
    logic [31:0]  m_magic [3] = '{32'h1CE1CEBB, 32'hD0D0D0D0, 32'hBAADA555};
    int           m_len   [3] = '{3, 6, 22};
    logic [1:0]   m_type;
    logic         m_bc;
    logic [151:0] m_pl;
    logic [15:0]  m_err, m_to;
    int           m_n;

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input bq_t b);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) begin
            c ^= {b[i], 8'h00};
            repeat (8) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    task automatic build(input int t, input logic [7:0] idb, input bq_t pl,
                         input logic [7:0] flip, output bq_t q);
        bq_t body;
        logic [31:0] mg;
        logic [15:0] c;
        mg = m_magic[t];
        body = {idb};
        foreach (pl[i]) body.push_back(pl[i]);
        c = ref_crc(body);
        q = {mg[31:24], mg[23:16], mg[15:8], mg[7:0]};
        foreach (body[i]) q.push_back(body[i]);
        q.push_back(c[15:8]);
        q.push_back(c[7:0] ^ flip);
    endtask

    // Frame-level expectation straight from the framing rules.
    task automatic model_frame(input bq_t q, input logic [7:0] board);
        int t, len;
        bq_t covered;
        logic pass, for_me;
        t = 0;
        for (int i = 0; i < 3; i++)
            if ({q[0], q[1], q[2], q[3]} == m_magic[i]) t = i;
        len = m_len[t];
        for (int i = 0; i < len - 2; i++) covered.push_back(q[4+i]);
        pass   = (ref_crc(covered) == {q[4+len-2], q[4+len-1]});
        for_me = (q[4] == board) || (q[4] == 8'hFF);
        if (pass && for_me) begin
            m_n++;
            m_type = 2'(t);
            m_bc   = (q[4] == 8'hFF);
            m_pl   = '0;
            for (int k = 0; k < len - 3; k++) m_pl[8*k +: 8] = q[5+k];
        end else if (!pass && m_err != 16'hFFFF) begin
            m_err++;
        end
    endtask

    task automatic send_bytes(input bq_t q, input int gap, output int last);
        last = 0;
        foreach (q[i]) begin
            @(posedge CLK); #1;
            rx_if.rx_valid = 1'b1;
            rx_if.rx_data  = q[i];
            last = cyc + 1;
            if (gap > 0) begin
                @(posedge CLK); #1;
                rx_if.rx_valid = 1'b0;
                repeat (gap - 1) @(posedge CLK);
            end
        end
        @(posedge CLK); #1;
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic verify(input string tag, input int exp_n, input int la, input int lb,
                          input logic [1:0] et, input logic eb, input logic [151:0] ep,
                          input logic [15:0] ee, input logic [15:0] eto);
        repeat (4) @(posedge CLK);
        #2;
        check({tag, " pulses"}, fv_q.size(), exp_n);
        if (exp_n > 0 && fv_q.size() > 0) check({tag, " latency1"}, fv_q[0], la + 1);
        if (exp_n > 1 && fv_q.size() > 1) check({tag, " latency2"}, fv_q[1], lb + 1);
        check({tag, " frame_type"}, frame_type, et);
        check({tag, " broadcast"}, frame_broadcast, eb);
        check({tag, " payload"}, payload, ep);
        check({tag, " crc_err_count"}, crc_err_count, ee);
        check({tag, " timeout_count"}, timeout_count, eto);
        check({tag, " busy"}, busy, 1'b0);
        fv_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        bq_t q, pl, rest;
        int la, lb, gap, sel;
        logic [7:0] idb, flip;

        reset_n = 1'b0;
        ID = 8'h05;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        m_type = '0; m_bc = 1'b0; m_pl = '0; m_err = '0; m_to = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("reset frame_valid", frame_valid, 1'b0);
        check("reset frame_type", frame_type, 2'd0);
        check("reset broadcast", frame_broadcast, 1'b0);
        check("reset payload", payload, 152'd0);
        check("reset busy", busy, 1'b0);
        check("reset crc_err_count", crc_err_count, 16'd0);
        check("reset timeout_count", timeout_count, 16'd0);
        reset_n = 1'b1;

        vt[0] = '{1, 8'h05, 8'h00, 1, 2'd1, 1'b0, 16'd0, 152'h563412};
        vt[1] = '{1, 8'hFF, 8'h00, 1, 2'd1, 1'b1, 16'd0, 152'h563412};
        vt[2] = '{1, 8'h07, 8'h00, 0, 2'd1, 1'b1, 16'd0, 152'h563412};
        vt[3] = '{1, 8'h05, 8'h01, 0, 2'd1, 1'b1, 16'd1, 152'h563412};
        vt[4] = '{2, 8'h05, 8'h00, 1, 2'd2, 1'b0, 16'd1,
                  152'h0f0e0d0c0b0a090807060504030201d0d0d0d0};
        vt[5] = '{0, 8'hFF, 8'h00, 1, 2'd0, 1'b1, 16'd1, 152'd0};

        foreach (vt[i]) begin
            pl = {};
            if (vt[i].t == 1) pl = {8'h12, 8'h34, 8'h56};
            if (vt[i].t == 2) begin
                pl = {8'hD0, 8'hD0, 8'hD0, 8'hD0};
                for (int k = 1; k <= 15; k++) pl.push_back(8'(k));
            end
            build(vt[i].t, vt[i].idb, pl, vt[i].flip, q);
            m_n = 0;
            model_frame(q, ID);
            send_bytes(q, 1, la);
            verify($sformatf("vec%0d", i), vt[i].fv, la, 0, vt[i].ty, vt[i].bc,
                   vt[i].pl, vt[i].err, 16'd0);
        end

        // Abandoned frame times out; then a slow but valid frame still lands.
        build(1, 8'h05, '{8'h12, 8'h34, 8'h56}, 8'h00, q);
        rest = q[0:6];
        send_bytes(rest, 1, la);
        repeat (105) @(posedge CLK);
        m_to++;
        verify("timeout", 0, 0, 0, m_type, m_bc, m_pl, m_err, m_to);
        build(0, 8'h05, '{}, 8'h00, q);
        m_n = 0;
        model_frame(q, ID);
        send_bytes(q, 60, la);
        verify("after_timeout", m_n, la, 0, m_type, m_bc, m_pl, m_err, m_to);

        // Reset in the middle of a type 2 body.
        pl = {};
        for (int k = 1; k <= 19; k++) pl.push_back(8'(k));
        build(2, 8'h05, pl, 8'h00, q);
        rest = q[0:9];
        send_bytes(rest, 1, la);
        #3 reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #3 reset_n = 1'b1;
        rest = q[10:$];
        send_bytes(rest, 1, la);
        m_type = '0; m_bc = 1'b0; m_pl = '0; m_err = '0; m_to = '0;
        verify("mid_reset", 0, 0, 0, 2'd0, 1'b0, 152'd0, 16'd0, 16'd0);

        // Two frames with no idle byte slot between them.
        build(1, 8'h05, '{8'hA1, 8'hA2, 8'hA3}, 8'h00, q);
        build(1, 8'hFF, '{8'hB1, 8'hB2, 8'hB3}, 8'h00, rest);
        m_n = 0;
        model_frame(q, ID);
        model_frame(rest, ID);
        foreach (rest[i]) q.push_back(rest[i]);
        send_bytes(q, 0, lb);
        la = lb - rest.size();
        verify("back2back", m_n, la, lb, m_type, m_bc, m_pl, m_err, m_to);

        for (int i = 0; i < 30; i++) begin
            int t;
            t = $urandom_range(0, 2);
            sel = $urandom_range(0, 2);
            if (sel == 0) idb = 8'h05;
            else if (sel == 1) idb = 8'hFF;
            else begin
                idb = 8'($urandom_range(0, 255));
                while (idb == 8'h05 || idb == 8'hFF) idb = 8'($urandom_range(0, 255));
            end
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            gap = $urandom_range(0, 3);
            pl = {};
            for (int k = 0; k < m_len[t] - 3; k++) pl.push_back(8'($urandom_range(0, 255)));
            build(t, idb, pl, flip, q);
            m_n = 0;
            model_frame(q, ID);
            send_bytes(q, gap, la);
            verify($sformatf("rand%0d", i), m_n, la, 0, m_type, m_bc, m_pl, m_err, m_to);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
